// File: rtl/k2_red_pkg.sv
// Shared constants and helpers for the K^2-RED modular reducer.
package k2_red_pkg;

    localparam int LOGQ_DEF  = 32;
    localparam int LOGQH_DEF = 15;
    localparam int W_C1_DEF  = 2 * LOGQ_DEF - (LOGQ_DEF - LOGQH_DEF) + 2;
    localparam int W_C2_DEF  = LOGQ_DEF + 2;

    function automatic int k2_red_lat(
        input int ff_in,
        input int ff_mul,
        input int use_csa,
        input int ff_csa,
        input int correct,
        input int ff_corr,
        input int ff_out
    );
        return ff_in + ff_mul + use_csa * ff_csa + correct * ff_corr + ff_out;
    endfunction

    function automatic int k2_red_wc1(input int logq, input int logqh);
        return 2 * logq - (logq - logqh) + 2;
    endfunction

    function automatic int k2_red_wc2(input int logq);
        return logq + 2;
    endfunction

endpackage

// File: rtl/k2_red_step.sv
// One K-RED step: y = qh * x[M-1:0] - (x >>> M), optionally in carry-save form.
module k2_red_step
    import k2_red_pkg::*;
#(
    parameter int W_IN    = 65,
    parameter int W_OUT   = 49,
    parameter int M       = 17,
    parameter int LOGQH   = 15,
    parameter int USE_CSA = 0,
    parameter int FF_CSA  = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [W_IN-1:0]         x,
    input  logic [LOGQH-1:0]        qh,
    output logic signed [W_OUT-1:0] y,
    output logic [LOGQH-1:0]        qh_out
);

    localparam int WH = W_IN - M;
    localparam int WP = LOGQH + M;

    logic [M-1:0]         lo;
    logic signed [WH-1:0] hi;
    logic [WP-1:0]        prod;
    logic [W_OUT-1:0]     a;
    logic [W_OUT-1:0]     b;

    assign lo   = x[M-1:0];
    assign hi   = x[W_IN-1:M];
    assign prod = WP'(qh) * WP'(lo);
    assign a    = W_OUT'(prod);
    // Subtraction as a + ~hi + 1; the +1 is the third CSA operand
    assign b    = ~W_OUT'(hi);

    generate
        if (USE_CSA != 0) begin : g_csa
            logic [W_OUT-1:0] one;
            logic [W_OUT-1:0] sum;
            logic [W_OUT-1:0] carry;
            logic [W_OUT-1:0] sum_r;
            logic [W_OUT-1:0] carry_r;
            logic [LOGQH-1:0] qh_r;

            assign one   = W_OUT'(1);
            assign sum   = a ^ b ^ one;
            assign carry = ((a & b) | (a & one) | (b & one)) << 1;

            if (FF_CSA != 0) begin : g_ff
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        sum_r   <= '0;
                        carry_r <= '0;
                        qh_r    <= '0;
                    end else begin
                        sum_r   <= sum;
                        carry_r <= carry;
                        qh_r    <= qh;
                    end
                end
            end else begin : g_noff
                assign sum_r   = sum;
                assign carry_r = carry;
                assign qh_r    = qh;
            end

            assign y      = sum_r + carry_r;
            assign qh_out = qh_r;
        end else begin : g_cpa
            assign y      = a + b + W_OUT'(1);
            assign qh_out = qh;
        end
    endgenerate

endmodule

// File: rtl/k2_red.sv
// Pipelined K^2-RED reducer: T == qH^2 * C (mod q), q = qH*2^M + 1.
module k2_red
    import k2_red_pkg::*;
#(
    parameter int LOGQ    = 32,
    parameter int LOGQH   = 15,
    parameter int CORRECT = 1,
    parameter int FF_IN   = 1,
    parameter int FF_MUL  = 1,
    parameter int USE_CSA = 0,
    parameter int FF_CSA  = 0,
    parameter int FF_CORR = 0,
    parameter int FF_OUT  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [LOGQH-1:0]    qH,
    input  logic [2*LOGQ-1:0]   C,
    output logic [LOGQ-1:0]     T
);

    localparam int K  = 2 * LOGQ;
    localparam int M  = LOGQ - LOGQH;
    localparam int W1 = k2_red_wc1(LOGQ, LOGQH);
    localparam int W2 = k2_red_wc2(LOGQ);
    localparam int LAT = k2_red_lat(FF_IN, FF_MUL, USE_CSA, FF_CSA,
                                    CORRECT, FF_CORR, FF_OUT);

    logic [K-1:0]         c_in;
    logic [LOGQH-1:0]     qh_in;
    logic signed [W1-1:0] c1;
    logic [LOGQH-1:0]     qh_s1;
    logic signed [W1-1:0] c1_m;
    logic [LOGQH-1:0]     qh_m;
    logic signed [W2-1:0] c2;
    logic [LOGQH-1:0]     qh_s2;
    logic signed [W2-1:0] c2_c;
    logic [LOGQH-1:0]     qh_c;
    logic [LOGQ-1:0]      t_pre;

    generate
        if (FF_IN != 0) begin : g_ff_in
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    c_in  <= '0;
                    qh_in <= '0;
                end else begin
                    c_in  <= C;
                    qh_in <= qH;
                end
            end
        end else begin : g_no_in
            assign c_in  = C;
            assign qh_in = qH;
        end
    endgenerate

    k2_red_step #(
        .W_IN(K + 1), .W_OUT(W1), .M(M), .LOGQH(LOGQH),
        .USE_CSA(0), .FF_CSA(0)
    ) u_step1 (
        .clk(clk), .rst_n(rst_n),
        .x({1'b0, c_in}), .qh(qh_in),
        .y(c1), .qh_out(qh_s1)
    );

    generate
        if (FF_MUL != 0) begin : g_ff_mul
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    c1_m <= '0;
                    qh_m <= '0;
                end else begin
                    c1_m <= c1;
                    qh_m <= qh_s1;
                end
            end
        end else begin : g_no_mul
            assign c1_m = c1;
            assign qh_m = qh_s1;
        end
    endgenerate

    k2_red_step #(
        .W_IN(W1), .W_OUT(W2), .M(M), .LOGQH(LOGQH),
        .USE_CSA(USE_CSA), .FF_CSA(FF_CSA)
    ) u_step2 (
        .clk(clk), .rst_n(rst_n),
        .x(c1_m), .qh(qh_m),
        .y(c2), .qh_out(qh_s2)
    );

    generate
        if (CORRECT != 0 && FF_CORR != 0) begin : g_ff_corr
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    c2_c <= '0;
                    qh_c <= '0;
                end else begin
                    c2_c <= c2;
                    qh_c <= qh_s2;
                end
            end
        end else begin : g_no_corr
            assign c2_c = c2;
            assign qh_c = qh_s2;
        end
    endgenerate

    generate
        if (CORRECT != 0) begin : g_correct
            logic [LOGQ-1:0]    q;
            logic signed [W2:0] cx;
            logic signed [W2:0] qx;
            logic signed [W2:0] cp;
            logic signed [W2:0] cm1;
            logic signed [W2:0] cm2;
            logic signed [W2:0] sel;
            logic               unused_sel;

            assign q   = {qh_c, {M{1'b0}}} + LOGQ'(1);
            assign cx  = (W2 + 1)'(c2_c);
            assign qx  = (W2 + 1)'(q);
            assign cp  = cx + qx;
            assign cm1 = cx - qx;
            assign cm2 = cx - (qx <<< 1);

            // -q < C2 < 3q, so the sign bits step monotonically
            always_comb begin
                sel = cm2;
                unique case (1'b1)
                    cx[W2]:             sel = cp;
                    !cx[W2] && cm1[W2]: sel = cx;
                    !cm1[W2] && cm2[W2]: sel = cm1;
                    default:            sel = cm2;
                endcase
            end

            assign t_pre      = sel[LOGQ-1:0];
            assign unused_sel = ^sel[W2:LOGQ];
        end else begin : g_raw
            logic unused_raw;

            assign t_pre      = c2_c[LOGQ-1:0];
            assign unused_raw = ^{c2_c[W2-1:LOGQ], qh_c};
        end
    endgenerate

    generate
        if (FF_OUT != 0) begin : g_ff_out
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) T <= '0;
                else        T <= t_pre;
            end
        end else begin : g_no_out
            assign T = t_pre;
        end
    endgenerate

endmodule

// File: tb/tb_k2_red.sv
// Scoreboard bench for k2_red: three pipeline configurations driven in lockstep.
module tb_k2_red;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [14:0] qh;
    logic [63:0] c;
    logic [31:0] t_arr [3];

    typedef struct {
        int          due;
        logic [31:0] v;
    } exp_t;

    exp_t sb [3][$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // Defaults: LAT 3
    k2_red dut_a (
        .clk(clk), .rst_n(rst_n), .qH(qh), .C(c), .T(t_arr[0])
    );

    // CSA with inner and correction registers: LAT 4
    k2_red #(
        .FF_IN(0), .FF_MUL(1), .USE_CSA(1), .FF_CSA(1),
        .FF_CORR(1), .FF_OUT(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .qH(qh), .C(c), .T(t_arr[1])
    );

    // Fully combinational: LAT 0
    k2_red #(
        .FF_IN(0), .FF_MUL(0), .USE_CSA(1), .FF_CSA(0),
        .FF_CORR(0), .FF_OUT(0)
    ) dut_c (
        .clk(clk), .rst_n(rst_n), .qH(qh), .C(c), .T(t_arr[2])
    );

    function automatic int lat_of(input int i);
        case (i)
            0:       return 3;
            1:       return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] q_of(input logic [14:0] h);
        return {h, 17'b0} + 32'd1;
    endfunction

    function automatic logic [31:0] ref_model(input logic [63:0] cv,
                                              input logic [14:0] h);
        logic [127:0] hh;
        logic [127:0] qq;
        logic [127:0] r;
        hh = 128'(h);
        qq = 128'(q_of(h));
        r  = (hh * hh * 128'(cv)) % qq;
        return r[31:0];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    task automatic drive(input logic [63:0] cv, input logic [14:0] h);
        logic [31:0] e;
        c  = cv;
        qh = h;
        e  = ref_model(cv, h);
        for (int i = 0; i < 3; i++)
            sb[i].push_back('{cyc + lat_of(i), e});
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            while (sb[i].size() > 0 && sb[i][0].due <= cyc) begin
                exp_t e;
                e = sb[i].pop_front();
                checks++;
                if (e.due != cyc) begin
                    failures++;
                    $display("FAIL sb%0d_missed: due %0d seen at %0d",
                             i, e.due, cyc);
                end else if (t_arr[i] !== e.v) begin
                    failures++;
                    $display("FAIL sb%0d_data: cycle %0d got %h expected %h",
                             i, cyc, t_arr[i], e.v);
                end
            end
        end
    end

    task automatic mid_reset();
        rst_n = 1'b0;
        #1;
        chk("flush_a", t_arr[0], 32'h0);
        chk("flush_b", t_arr[1], 32'h0);
        for (int i = 0; i < 3; i++) sb[i].delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // Registered configs must read zero until new data arrives
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < lat_of(i); k++)
                sb[i].push_back('{cyc + k, 32'h0});
    endtask

    initial begin
        logic [31:0] q0;
        logic [63:0] qsq;
        logic [63:0] rc;
        logic [14:0] rh;
        int          wait_n;

        rst_n = 1'b0;
        c     = '0;
        qh    = 15'h4001;
        q0    = q_of(15'h4001);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_a", t_arr[0], 32'h0);
        chk("reset_b", t_arr[1], 32'h0);
        rst_n = 1'b1;

        @(posedge clk); #1; drive(64'd1, 15'h4001);
        @(posedge clk); #1; drive(64'd0, 15'h4001);
        @(posedge clk); #1; drive(64'h20000, 15'h4001);
        @(posedge clk); #1; drive(64'(q0), 15'h4001);
        @(posedge clk); #1; drive(64'(q0 - 1) * 64'(q0 - 1), 15'h4001);
        @(posedge clk); #1; drive(64'(q0) * 64'd7, 15'h4001);

        for (int n = 0; n < 300; n++) begin
            @(posedge clk);
            #1;
            if (n == 150) mid_reset();
            rh  = {1'b1, 14'($urandom)};
            qsq = 64'(q_of(rh)) * 64'(q_of(rh));
            rc  = {$urandom, $urandom};
            if (n % 7 == 3) rc = qsq - 64'd1;
            else            rc = rc % qsq;
            drive(rc, rh);
        end

        @(posedge clk);
        #1;
        c = '0;
        wait_n = 0;
        while ((sb[0].size() + sb[1].size() + sb[2].size()) > 0
               && wait_n < 20) begin
            @(posedge clk);
            wait_n++;
        end
        #1;
        checks++;
        if ((sb[0].size() + sb[1].size() + sb[2].size()) > 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0",
                     sb[0].size() + sb[1].size() + sb[2].size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
